// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the pipelined WISC CPU.
// Issues req/ready fetches, holds one response in a skid buffer under stall, and handles redirects and HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus_two,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, BUF, DROP, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] stale_addr_q, stale_addr_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pc_q, buf_pc_d;
  logic        buf_hlt_q, buf_hlt_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [15:0] if_id_instr_q, if_id_instr_d;
  logic [15:0] if_id_pc_q, if_id_pc_d;
  logic [15:0] if_id_pc_plus_two_q, if_id_pc_plus_two_d;

  logic        rdata_is_hlt;
  logic [15:0] pc_seq;

  assign rdata_is_hlt = (imem_rdata[15:12] == HLT_OPCODE);
  // A fetched HLT freezes the PC on its own address; anything else advances by one word.
  assign pc_seq       = rdata_is_hlt ? pc_q : pc_q + 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= FETCH;
      pc_q                <= RESET_PC;
      stale_addr_q        <= 16'h0000;
      buf_instr_q         <= 16'h0000;
      buf_pc_q            <= 16'h0000;
      buf_hlt_q           <= 1'b0;
      if_id_valid_q       <= 1'b0;
      if_id_instr_q       <= 16'h0000;
      if_id_pc_q          <= 16'h0000;
      if_id_pc_plus_two_q <= 16'h0000;
    end else begin
      state_q             <= state_d;
      pc_q                <= pc_d;
      stale_addr_q        <= stale_addr_d;
      buf_instr_q         <= buf_instr_d;
      buf_pc_q            <= buf_pc_d;
      buf_hlt_q           <= buf_hlt_d;
      if_id_valid_q       <= if_id_valid_d;
      if_id_instr_q       <= if_id_instr_d;
      if_id_pc_q          <= if_id_pc_d;
      if_id_pc_plus_two_q <= if_id_pc_plus_two_d;
    end
  end

  // A redirect while a request is still unanswered must wait out that stale response in DROP.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      case (state_q)
        FETCH:   state_d = imem_ready ? FETCH : DROP;
        DROP:    state_d = imem_ready ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: if (imem_ready) state_d = stall ? BUF : (rdata_is_hlt ? HALT : FETCH);
        BUF:   if (!stall) state_d = buf_hlt_q ? HALT : FETCH;
        DROP:  if (imem_ready) state_d = FETCH;
        HALT:  state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    pc_d                = pc_q;
    stale_addr_d        = stale_addr_q;
    buf_instr_d         = buf_instr_q;
    buf_pc_d            = buf_pc_q;
    buf_hlt_d           = buf_hlt_q;
    if_id_valid_d       = if_id_valid_q;
    if_id_instr_d       = if_id_instr_q;
    if_id_pc_d          = if_id_pc_q;
    if_id_pc_plus_two_d = if_id_pc_plus_two_q;
    if (redirect) begin
      pc_d          = redirect_pc;
      if_id_valid_d = 1'b0;
      buf_hlt_d     = 1'b0;
      if (state_q == FETCH && !imem_ready) stale_addr_d = pc_q;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_seq;
            if (stall) begin
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc_q;
              buf_hlt_d   = rdata_is_hlt;
            end else begin
              if_id_valid_d       = 1'b1;
              if_id_instr_d       = imem_rdata;
              if_id_pc_d          = pc_q;
              if_id_pc_plus_two_d = pc_q + 16'd2;
            end
          end else if (!stall) begin
            if_id_valid_d = 1'b0;
          end
        end
        BUF: begin
          if (!stall) begin
            if_id_valid_d       = 1'b1;
            if_id_instr_d       = buf_instr_q;
            if_id_pc_d          = buf_pc_q;
            if_id_pc_plus_two_d = buf_pc_q + 16'd2;
          end
        end
        HALT: begin
          if (!stall) if_id_valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req          = !rst && (state_q == FETCH || state_q == DROP);
    imem_addr         = (state_q == DROP) ? stale_addr_q : pc_q;
    pc                = pc_q;
    if_id_valid       = if_id_valid_q;
    if_id_instr       = if_id_instr_q;
    if_id_pc          = if_id_pc_q;
    if_id_pc_plus_two = if_id_pc_plus_two_q;
    halted            = (state_q == HALT);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a vector table drives memory/control inputs cycle by cycle,
// expected post-edge state goes through a scoreboard queue, plus hand-written reset and latency sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] pc;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus_two;
  logic        halted;

  int passCount  = 0;
  int checkCount = 0;

  fetch_stage #(.RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc(pc), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus_two(if_id_pc_plus_two), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        ready;
    logic [15:0] rdata;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic [15:0] exp_ifpc;
    logic [15:0] exp_ppt;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[28];
  vec_t sbQueue[$];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drive one row before the edge, check request outputs, then compare registered state after the edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    stall = v.stall; redirect = v.redirect; redirect_pc = v.rpc;
    imem_ready = v.ready; imem_rdata = v.rdata;
    #1;
    checkOutput($sformatf("v%0d imem_req", idx), {15'd0, imem_req}, {15'd0, v.exp_req});
    if (v.exp_req) checkOutput($sformatf("v%0d imem_addr", idx), imem_addr, v.exp_addr);
    sbQueue.push_back(v);
    @(posedge clk);
    #1;
    e = sbQueue.pop_front();
    checkOutput($sformatf("v%0d pc", idx), pc, e.exp_pc);
    checkOutput($sformatf("v%0d if_id_valid", idx), {15'd0, if_id_valid}, {15'd0, e.exp_valid});
    checkOutput($sformatf("v%0d halted", idx), {15'd0, halted}, {15'd0, e.exp_halted});
    if (e.exp_valid) begin
      checkOutput($sformatf("v%0d if_id_instr", idx), if_id_instr, e.exp_instr);
      checkOutput($sformatf("v%0d if_id_pc", idx), if_id_pc, e.exp_ifpc);
      checkOutput($sformatf("v%0d if_id_pc_plus_two", idx), if_id_pc_plus_two, e.exp_ppt);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_ready = 1'b0; imem_rdata = 16'h0;
    #1;
    checkOutput("reset imem_req", {15'd0, imem_req}, 16'h0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    checkOutput("reset imem_req held", {15'd0, imem_req}, 16'h0);
    checkOutput("reset pc", pc, 16'h0000);
    checkOutput("reset if_id_valid", {15'd0, if_id_valid}, 16'h0);
    checkOutput("reset if_id_instr", if_id_instr, 16'h0000);
    checkOutput("reset if_id_pc", if_id_pc, 16'h0000);
    checkOutput("reset if_id_pc_plus_two", if_id_pc_plus_two, 16'h0000);
    checkOutput("reset halted", {15'd0, halted}, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic rd, input logic [15:0] rpc,
                              input logic rdy, input logic [15:0] rdata,
                              input logic ereq, input logic [15:0] eaddr, input logic [15:0] epc,
                              input logic ev, input logic [15:0] ei, input logic [15:0] eip,
                              input logic [15:0] eppt, input logic eh);
    vec_t v;
    v.stall = st; v.redirect = rd; v.rpc = rpc; v.ready = rdy; v.rdata = rdata;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_pc = epc; v.exp_valid = ev;
    v.exp_instr = ei; v.exp_ifpc = eip; v.exp_ppt = eppt; v.exp_halted = eh;
    return v;
  endfunction

  initial begin
    int waitCycles;
    //          st rd rpc      rdy rdata     req addr     pc       v  instr    ifpc     ppt      h
    vecs[0]  = mk(0, 0, 16'h0000, 1, 16'h8123, 1, 16'h0000, 16'h0002, 1, 16'h8123, 16'h0000, 16'h0002, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h9045, 1, 16'h0002, 16'h0004, 1, 16'h9045, 16'h0002, 16'h0004, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 1, 16'hA100, 1, 16'h0004, 16'h0006, 1, 16'hA100, 16'h0004, 16'h0006, 0);
    vecs[3]  = mk(0, 1, 16'h0002, 1, 16'hDEAD, 1, 16'h0006, 16'h0002, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[4]  = mk(1, 0, 16'h0000, 1, 16'h1234, 1, 16'h0002, 16'h0004, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[5]  = mk(1, 0, 16'h0000, 1, 16'hBEEF, 0, 16'h0000, 16'h0004, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0004, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0004, 1, 16'h1234, 16'h0002, 16'h0004, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0004, 16'h0006, 1, 16'h2222, 16'h0004, 16'h0006, 0);
    vecs[9]  = mk(0, 1, 16'h0010, 1, 16'h0000, 1, 16'h0006, 16'h0010, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[10] = mk(0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0010, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[11] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[12] = mk(0, 0, 16'h0000, 1, 16'h5555, 1, 16'h0010, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[13] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[14] = mk(0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0040, 16'h0042, 1, 16'h3333, 16'h0040, 16'h0042, 0);
    vecs[15] = mk(1, 1, 16'h0008, 0, 16'h0000, 1, 16'h0042, 16'h0008, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[16] = mk(0, 0, 16'h0000, 1, 16'h7777, 1, 16'h0042, 16'h0008, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[17] = mk(0, 0, 16'h0000, 1, 16'hF000, 1, 16'h0008, 16'h0008, 1, 16'hF000, 16'h0008, 16'h000A, 1);
    vecs[18] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0008, 1, 16'hF000, 16'h0008, 16'h000A, 1);
    vecs[19] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0008, 0, 16'h0000, 16'h0000, 16'h0000, 1);
    vecs[20] = mk(0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0000, 16'h0008, 0, 16'h0000, 16'h0000, 16'h0000, 1);
    vecs[21] = mk(0, 1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 16'h0020, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[22] = mk(0, 0, 16'h0000, 1, 16'h4444, 1, 16'h0020, 16'h0022, 1, 16'h4444, 16'h0020, 16'h0022, 0);
    vecs[23] = mk(0, 1, 16'hFFFE, 1, 16'h0000, 1, 16'h0022, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[24] = mk(0, 0, 16'h0000, 1, 16'h6666, 1, 16'hFFFE, 16'h0000, 1, 16'h6666, 16'hFFFE, 16'h0000, 0);
    vecs[25] = mk(1, 0, 16'h0000, 1, 16'hF123, 1, 16'h0000, 16'h0000, 1, 16'h6666, 16'hFFFE, 16'h0000, 0);
    vecs[26] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'hF123, 16'h0000, 16'h0002, 1);
    vecs[27] = mk(0, 0, 16'h0000, 1, 16'h2468, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 1);

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_ready = 1'b0; imem_rdata = 16'h0;
    doReset();
    checkOutput("post-reset pc", pc, 16'h0000);

    for (int i = 0; i < 28; i++) applyStimulus(vecs[i], i);

    // Reset while a request is outstanding, then a two-cycle-latency fetch.
    @(negedge clk);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 16'h0030; imem_ready = 1'b0;
    @(posedge clk); #1;
    redirect = 1'b0;
    doReset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      imem_ready = 1'b0; #1;
      checkOutput($sformatf("lat req c%0d", c), {15'd0, imem_req}, 16'h0001);
      checkOutput($sformatf("lat addr c%0d", c), imem_addr, 16'h0000);
    end
    @(negedge clk);
    imem_ready = 1'b1; imem_rdata = 16'hABCD;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    waitCycles = 0;
    while (!if_id_valid && waitCycles < 10) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("lat wait", waitCycles[15:0], 16'h0000);
    checkOutput("lat instr", if_id_instr, 16'hABCD);
    checkOutput("lat if_id_pc", if_id_pc, 16'h0000);
    checkOutput("lat pc", pc, 16'h0002);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
